// File: rtl/toggle_hs_pkg.sv
// Shared types for the toggle-handshake receiver.
// Receiver FSM: IDLE accepts words directly, PEND holds one word while the FIFO is full.
package toggle_hs_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } rx_state_t;

endpackage

// File: rtl/toggle_edge_detect.sv
// Synchroniser chain plus previous-level register; flags every transition of tog_in.
// SYNC_STAGES = 0 means tog_in is already synchronous to clk and is used directly.
module toggle_edge_detect
   import toggle_hs_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic tog_in,
   output logic tog_s,
   output logic tog_edge
);

   logic r_prev;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign tog_s = tog_in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] r_sync;
         if (SYNC_STAGES == 1) begin : g_one
            always_ff @(posedge clk) begin
               if (rst) r_sync <= '0;
               else     r_sync <= tog_in;
            end
         end else begin : g_chain
            always_ff @(posedge clk) begin
               if (rst) r_sync <= '0;
               else     r_sync <= {r_sync[SYNC_STAGES-2:0], tog_in};
            end
         end
         assign tog_s = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) r_prev <= 1'b0;
      else     r_prev <= tog_s;
   end

   assign tog_edge = tog_s ^ r_prev;

endmodule

// File: rtl/toggle_hs_receiver.sv
// Receiving end of a two-phase toggle handshake: captures one word per req_tog transition
// into a first-word-fall-through FIFO and answers each accepted word with an ack_tog toggle.
//
// state | meaning
// IDLE  | words go straight into the FIFO on each detected edge
// PEND  | FIFO was full on an edge; word parked in r_hold, ack withheld until a pop
module toggle_hs_receiver
   import toggle_hs_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_tog,
   input  logic [DATA_W-1:0]        req_data,
   output logic                     ack_tog,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_hold;
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_ack;
   logic              r_ovf;
   rx_state_t         r_state;

   logic              w_unused_req_s;
   logic              w_edge;
   logic              w_pop;
   logic              w_push_ok;
   logic              w_push;
   logic              w_to_pend;
   logic [DATA_W-1:0] w_wr_data;

   toggle_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge (
      .clk      (clk),
      .rst      (rst),
      .tog_in   (req_tog),
      .tog_s    (w_unused_req_s),
      .tog_edge (w_edge)
   );

   assign w_pop     = (r_count != '0) && out_ready;
   // A pop in the same cycle frees a slot, so a full FIFO can still take the word.
   assign w_push_ok = (r_count < CNT_FULL) || w_pop;

   always_comb begin
      w_push    = 1'b0;
      w_to_pend = 1'b0;
      w_wr_data = req_data;
      case (r_state)
         IDLE: begin
            w_push    = w_edge && w_push_ok;
            w_to_pend = w_edge && !w_push_ok;
         end
         PEND: begin
            w_push    = w_pop;
            w_wr_data = r_hold;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_ack    <= 1'b0;
         r_ovf    <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_ack    <= ~r_ack;
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: ;
         endcase

         case (r_state)
            IDLE: if (w_to_pend) r_state <= PEND;
            PEND: begin
               // Sender toggled again before its parked word was acknowledged; that word is lost.
               if (w_edge) r_ovf <= 1'b1;
               if (w_pop)  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)    r_mem[r_wr_ptr] <= w_wr_data;
      if (w_to_pend) r_hold <= req_data;
   end

   assign ack_tog   = r_ack;
   assign out_valid = (r_count != '0);
   assign out_data  = r_mem[r_rd_ptr];
   assign count     = r_count;
   assign overflow  = r_ovf;

endmodule
